// File: rtl/uop_fetch_seq.sv
// uop_fetch_seq: accepts one macro-op at a time and strobes uop_fetch_ctrl
// so it streams micro-op bundles until the ROM end flag. It also squashes the
// speculative bundle after the end bundle, honours uop-queue backpressure and
// flushes, and traps sequences that run past MAX_BUNDLES.
module uop_fetch_seq #(
    parameter int MAX_BUNDLES = 8,
    parameter int CNT_WIDTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 macro_valid,
    input  logic [7:0]           macro_op,
    output logic                 macro_ready,
    output logic [7:0]           macro_op_q,
    input  logic                 flush,
    input  logic                 uq_ready,
    input  logic                 rom_end,
    output logic                 macro_fetch,
    output logic                 uop_pc_ready,
    output logic                 bundle_valid,
    output logic [CNT_WIDTH-1:0] bundle_count,
    output logic                 busy,
    output logic                 runaway
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_BUNDLES);

    state_t               state_r, state_s;
    logic [7:0]           op_r, op_s;
    logic                 first_r, first_s;
    logic                 bundle_valid_r, bundle_valid_s;
    logic [CNT_WIDTH-1:0] count_r, count_s;
    logic                 runaway_r, runaway_s;

    logic end_seen_s;
    logic limit_s;
    logic issue_s;
    logic ready_s;
    logic accept_s;

    // The bundle presented this cycle carries the end flag.
    assign end_seen_s = bundle_valid_r & rom_end;
    assign limit_s    = (count_r == MAX_CNT);
    // Gate with rst so every output reads 0 while reset is held.
    assign issue_s    = rst & (state_r == RUN) & uq_ready & ~flush & ~end_seen_s & ~limit_s;
    // A new op may enter in the same cycle its predecessor's end is seen.
    assign ready_s    = rst & ~flush & ((state_r == IDLE) | ((state_r == RUN) & end_seen_s));
    assign accept_s   = macro_valid & ready_s;

    // Next-state logic: flush beats end/accept, which beats issue.
    always_comb begin
        state_s        = state_r;
        op_s           = op_r;
        first_s        = first_r;
        count_s        = count_r;
        runaway_s      = runaway_r;
        bundle_valid_s = issue_s;
        case (state_r)
            IDLE: begin
                if (flush) begin
                    first_s        = 1'b0;
                    count_s        = '0;
                    bundle_valid_s = 1'b0;
                end else if (accept_s) begin
                    state_s = RUN;
                    op_s    = macro_op;
                    first_s = 1'b1;
                    count_s = '0;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (flush) begin
                    state_s        = IDLE;
                    first_s        = 1'b0;
                    count_s        = '0;
                    bundle_valid_s = 1'b0;
                end else if (end_seen_s) begin
                    if (accept_s) begin
                        state_s = RUN;
                        op_s    = macro_op;
                        first_s = 1'b1;
                        count_s = '0;
                    end else begin
                        state_s = IDLE;
                        first_s = 1'b0;
                    end
                end else if (limit_s & bundle_valid_r) begin
                    // Limit reached and the last bundle was not the end: trap.
                    state_s        = HALT;
                    runaway_s      = 1'b1;
                    bundle_valid_s = 1'b0;
                end else if (issue_s) begin
                    first_s = 1'b0;
                    count_s = limit_s ? count_r : (count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1});
                end else begin
                    state_s = RUN;
                end
            end
            HALT: begin
                // Only reset leaves HALT.
                state_s        = HALT;
                bundle_valid_s = 1'b0;
            end
            default: begin
                state_s        = IDLE;
                first_s        = 1'b0;
                count_s        = '0;
                bundle_valid_s = 1'b0;
            end
        endcase
    end

    // State register with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r        <= IDLE;
            op_r           <= 8'd0;
            first_r        <= 1'b0;
            bundle_valid_r <= 1'b0;
            count_r        <= '0;
            runaway_r      <= 1'b0;
        end else begin
            state_r        <= state_s;
            op_r           <= op_s;
            first_r        <= first_s;
            bundle_valid_r <= bundle_valid_s;
            count_r        <= count_s;
            runaway_r      <= runaway_s;
        end
    end

    assign macro_ready  = ready_s;
    assign macro_op_q   = op_r;
    assign uop_pc_ready = issue_s;
    assign macro_fetch  = issue_s & first_r;
    assign bundle_valid = bundle_valid_r;
    assign bundle_count = count_r;
    assign busy         = (state_r != IDLE);
    assign runaway      = runaway_r;

endmodule
